host_fifo_responder: RTL and testbench
======================================

HOST_FIFO_RESPONDER -- requirements
Module: host_fifo_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, host data word width.
REQ-002 SHALL have parameter ADDR_W, default 10, buffer address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port iCLK  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port iRST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port iWR  in  1  write strobe; one word accepted per cycle high.
REQ-006 SHALL have port iWR_DATA  in  DATA_W  write word, sampled with iWR.
REQ-007 SHALL have port iWR_ADDR  in  ADDR_W  write start address, loaded by iWR_LOAD.
REQ-008 SHALL have port iWR_MAX_ADDR  in  ADDR_W  last write address before wrap.
REQ-009 SHALL have port iWR_LOAD  in  1  write-side reload, one-cycle pulse.
REQ-010 SHALL have port iRD  in  1  read strobe; one word returned per cycle high.
REQ-011 SHALL have port iRD_ADDR, iRD_MAX_ADDR  in  ADDR_W  read start and wrap addresses.
REQ-012 SHALL have port iRD_LOAD  in  1  read-side reload, one-cycle pulse.
REQ-013 SHALL have port oRD_DATA  out  DATA_W  read word, registered.
REQ-014 SHALL have port oRD_VALID  out  1  high one cycle after each accepted iRD.
REQ-015 SHALL have port oREADY  out  1  high when INIT sweep is complete.
REQ-016 SHALL have port oLEVEL  out  ADDR_W+1  words written but not yet read.
REQ-017 SHALL have port oOVERFLOW, oUNDERFLOW  out  1  sticky error flags.

Function
REQ-018 SHALL implement FSM states INIT and RUN; INIT is entered on reset.
REQ-019 INIT SHALL write 0 to every address 0..DEPTH-1, one per cycle; after DEPTH cycles -> RUN, oREADY=1.
REQ-020 SHALL ignore iWR, iRD, iWR_LOAD and iRD_LOAD in INIT; no flag set.
REQ-021 In RUN, iWR SHALL write iWR_DATA at wr_ptr; wr_ptr==iWR_MAX_ADDR -> wr_ptr=iWR_ADDR, else wr_ptr+1 (mod DEPTH).
REQ-022 In RUN, iRD SHALL drive mem[rd_ptr] onto oRD_DATA next cycle with oRD_VALID=1; rd_ptr wraps like wr_ptr, using iRD_ADDR/iRD_MAX_ADDR.
REQ-023 oRD_DATA SHALL hold its last value when oRD_VALID=0.
REQ-024 oLEVEL: +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read.
REQ-025 iWR when oLEVEL==DEPTH SHALL be dropped (pointer and memory unchanged) and SHALL set oOVERFLOW.
REQ-026 iRD when oLEVEL==0 SHALL still return mem[rd_ptr] and advance rd_ptr; sets oUNDERFLOW; oLEVEL stays 0.
REQ-027 Write and read of the same address in the same cycle SHALL return the old word (read-before-write).
REQ-028 iWR_LOAD SHALL set wr_ptr=iWR_ADDR, oLEVEL=0 and clear both flags; iWR in the same cycle is ignored.
REQ-029 iRD_LOAD SHALL set rd_ptr=iRD_ADDR, oLEVEL=0 and clear both flags; iRD in the same cycle is ignored and oRD_VALID=0.
REQ-030 Simultaneous iWR_LOAD and iRD_LOAD SHALL apply both reloads.
REQ-031 iWR_MAX_ADDR < iWR_ADDR SHALL wrap through DEPTH-1 -> 0 before reaching MAX; iRD likewise.

Reset
REQ-032 iRST SHALL asynchronously force: state=INIT, wr_ptr=rd_ptr=0, oLEVEL=0, oRD_DATA=0, oRD_VALID=0, oREADY=0, flags=0.
REQ-033 Reset asserted mid-operation (including mid-INIT) SHALL restart a full INIT sweep after deassertion.
REQ-034 Memory contents SHALL NOT be reset by iRST; only the INIT sweep clears them.

Structure
REQ-035 Package host_fifo_pkg SHALL hold the state enum (INIT, RUN) and the DATA_W/ADDR_W defaults.
REQ-036 Storage SHALL be the single sub-module hfr_ram: simple dual-port, one write port, one registered read port, read-before-write.

Verification
REQ-037 Reset released -> oREADY=0 for exactly 1024 cycles, then 1; every address reads 0.
REQ-038 Addresses 0..127 set by LOAD; write 128 words 0x0000..0x007F, then 128 reads -> oRD_DATA 0x0000..0x007F, each one cycle after iRD; oLEVEL ends at 0.
REQ-039 WR_ADDR=4, WR_MAX_ADDR=6; write A,B,C,D -> addresses 4,5,6,4; reads from 4 return D,B,C.
REQ-040 1024 writes, then a 1025th write -> oOVERFLOW=1, oLEVEL=1024; an iRD on empty buffer -> oUNDERFLOW=1; iWR_LOAD -> both flags 0.
REQ-041 Simultaneous iWR and iRD with oLEVEL=5 -> oLEVEL stays 5; iRST pulse mid-stream -> all outputs reach REQ-032 values without waiting for a clock edge.

Source files
------------

// File: rtl/host_fifo_pkg.sv
// Shared types and default geometry for the host FIFO responder.
package host_fifo_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/hfr_ram.sv
// Simple dual-port word store: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module hfr_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // The array itself is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/host_fifo_responder.sv
// Host-facing circular buffer: clears its storage after reset, then serves
// independent write/read pointers with programmable start and wrap addresses.
module host_fifo_responder
    import host_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iWR,
    input  logic [DATA_W-1:0] iWR_DATA,
    input  logic [ADDR_W-1:0] iWR_ADDR,
    input  logic [ADDR_W-1:0] iWR_MAX_ADDR,
    input  logic              iWR_LOAD,
    input  logic              iRD,
    input  logic [ADDR_W-1:0] iRD_ADDR,
    input  logic [ADDR_W-1:0] iRD_MAX_ADDR,
    input  logic              iRD_LOAD,
    output logic [DATA_W-1:0] oRD_DATA,
    output logic              oRD_VALID,
    output logic              oREADY,
    output logic [ADDR_W:0]   oLEVEL,
    output logic              oOVERFLOW,
    output logic              oUNDERFLOW
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] init_cnt;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              full, empty;
    logic              wr_acc, rd_acc, any_load;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    // Advance a pointer, jumping back to its start once it sits on its last address.
    function automatic logic [ADDR_W-1:0] ptr_next(
        input logic [ADDR_W-1:0] p,
        input logic [ADDR_W-1:0] start,
        input logic [ADDR_W-1:0] last
    );
        return (p == last) ? start : p + 1'b1;
    endfunction

    assign full     = (oLEVEL == FULL_LEVEL);
    assign empty    = (oLEVEL == '0);
    assign any_load = iWR_LOAD | iRD_LOAD;
    assign oREADY   = (state == RUN);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            state <= INIT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        wr_acc    = 1'b0;
        rd_acc    = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = wr_ptr;
        ram_wdata = iWR_DATA;
        case (state)
            INIT: begin
                ram_we    = 1'b1;
                ram_waddr = init_cnt;
                ram_wdata = '0;
                if (&init_cnt)
                    state_nx = RUN;
            end
            RUN: begin
                wr_acc = iWR & ~iWR_LOAD & ~full;
                rd_acc = iRD & ~iRD_LOAD;
                ram_we = wr_acc;
            end
            default: state_nx = INIT;
        endcase
    end

    // Sweep counter wraps to zero at the end of INIT, ready for the next reset.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            init_cnt <= '0;
        else if (state == INIT)
            init_cnt <= init_cnt + 1'b1;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            oLEVEL     <= '0;
            oOVERFLOW  <= 1'b0;
            oUNDERFLOW <= 1'b0;
            oRD_VALID  <= 1'b0;
        end else begin
            oRD_VALID <= rd_acc;
            if (state == RUN) begin
                if (iWR_LOAD)
                    wr_ptr <= iWR_ADDR;
                else if (wr_acc)
                    wr_ptr <= ptr_next(wr_ptr, iWR_ADDR, iWR_MAX_ADDR);

                if (iRD_LOAD)
                    rd_ptr <= iRD_ADDR;
                else if (rd_acc)
                    rd_ptr <= ptr_next(rd_ptr, iRD_ADDR, iRD_MAX_ADDR);

                // A reload of either side restarts occupancy and error tracking.
                if (any_load) begin
                    oLEVEL     <= '0;
                    oOVERFLOW  <= 1'b0;
                    oUNDERFLOW <= 1'b0;
                end else begin
                    if (iWR && full)
                        oOVERFLOW <= 1'b1;
                    if (rd_acc && empty)
                        oUNDERFLOW <= 1'b1;
                    if (wr_acc && !rd_acc)
                        oLEVEL <= oLEVEL + 1'b1;
                    else if (!wr_acc && rd_acc && !empty)
                        oLEVEL <= oLEVEL - 1'b1;
                end
            end
        end
    end

    hfr_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (iCLK),
        .rst   (iRST),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (oRD_DATA)
    );

endmodule

// File: tb/tb_host_fifo_responder.sv
// Directed bench for host_fifo_responder; read data is checked against a queue
// of expected words pushed as each read is issued.
module tb_host_fifo_responder;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iWR, iRD, iWR_LOAD, iRD_LOAD;
    logic [DW-1:0] iWR_DATA;
    logic [AW-1:0] iWR_ADDR, iWR_MAX_ADDR, iRD_ADDR, iRD_MAX_ADDR;
    logic [DW-1:0] oRD_DATA;
    logic          oRD_VALID, oREADY, oOVERFLOW, oUNDERFLOW;
    logic [AW:0]   oLEVEL;

    int            nchk = 0;
    int            npass = 0;
    logic [DW-1:0] q[$];
    bit            exp_vld = 1'b0;
    bit            exp_vld_q = 1'b0;

    always #5 iCLK = ~iCLK;

    host_fifo_responder #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iWR          (iWR),
        .iWR_DATA     (iWR_DATA),
        .iWR_ADDR     (iWR_ADDR),
        .iWR_MAX_ADDR (iWR_MAX_ADDR),
        .iWR_LOAD     (iWR_LOAD),
        .iRD          (iRD),
        .iRD_ADDR     (iRD_ADDR),
        .iRD_MAX_ADDR (iRD_MAX_ADDR),
        .iRD_LOAD     (iRD_LOAD),
        .oRD_DATA     (oRD_DATA),
        .oRD_VALID    (oRD_VALID),
        .oREADY       (oREADY),
        .oLEVEL       (oLEVEL),
        .oOVERFLOW    (oOVERFLOW),
        .oUNDERFLOW   (oUNDERFLOW)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Whether a read response is due is latched at the edge that samples the strobe.
    always @(posedge iCLK) exp_vld_q = exp_vld;

    always @(negedge iCLK) begin
        logic [31:0] e;
        chk("rd_valid", 32'(oRD_VALID), 32'(exp_vld_q));
        if (oRD_VALID === 1'b1) begin
            e = (q.size() != 0) ? 32'(q.pop_front()) : 32'hFFFF_FFFF;
            chk("rd_data", 32'(oRD_DATA), e);
        end
    end

    task automatic tick();
        @(negedge iCLK);
    endtask

    task automatic idle();
        iWR = 1'b0; iRD = 1'b0; iWR_LOAD = 1'b0; iRD_LOAD = 1'b0; exp_vld = 1'b0;
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        iWR = 1'b1; iWR_DATA = d; iRD = 1'b0; exp_vld = 1'b0;
        tick();
        iWR = 1'b0;
    endtask

    task automatic do_read(input logic [DW-1:0] e);
        iRD = 1'b1; exp_vld = 1'b1; q.push_back(e);
        tick();
        iRD = 1'b0; exp_vld = 1'b0;
    endtask

    task automatic do_rw(input logic [DW-1:0] d, input logic [DW-1:0] e);
        iWR = 1'b1; iWR_DATA = d; iRD = 1'b1; exp_vld = 1'b1; q.push_back(e);
        tick();
        iWR = 1'b0; iRD = 1'b0; exp_vld = 1'b0;
    endtask

    // Strobes ride along with the reloads and must be ignored by the DUT.
    task automatic load(input bit w, input bit r, input logic [AW-1:0] wa, input logic [AW-1:0] wm,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rm);
        iWR_ADDR = wa; iWR_MAX_ADDR = wm; iRD_ADDR = ra; iRD_MAX_ADDR = rm;
        iWR_LOAD = w; iRD_LOAD = r; iWR = w; iRD = r; iWR_DATA = 16'hDEAD; exp_vld = 1'b0;
        tick();
        idle();
    endtask

    task automatic drain();
        tick();
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (oREADY !== 1'b1 && cyc < 1100) begin
            tick();
            cyc++;
        end
        chk(tag, 32'(cyc), 32'd1024);
    endtask

    initial begin
        iRST = 1'b1;
        idle();
        iWR_DATA = '0; iWR_ADDR = '0; iWR_MAX_ADDR = '0; iRD_ADDR = '0; iRD_MAX_ADDR = '0;
        tick(); tick();
        chk("rst_ready", 32'(oREADY), 32'd0);
        chk("rst_level", 32'(oLEVEL), 32'd0);
        chk("rst_data", 32'(oRD_DATA), 32'd0);
        chk("rst_ovf", 32'(oOVERFLOW), 32'd0);
        chk("rst_udf", 32'(oUNDERFLOW), 32'd0);

        // INIT sweep with write/read strobes held high; all must be ignored
        iWR = 1'b1; iRD = 1'b1; iWR_DATA = 16'hFFFF;
        iRST = 1'b0;
        wait_ready("init_cycles");
        idle();
        chk("init_level", 32'(oLEVEL), 32'd0);
        chk("init_ovf", 32'(oOVERFLOW), 32'd0);
        chk("init_udf", 32'(oUNDERFLOW), 32'd0);

        // Whole array reads back zero; reads on an empty buffer raise underflow
        load(1'b1, 1'b1, 10'd0, 10'd127, 10'd0, 10'd1023);
        for (int i = 0; i < 1024; i++) do_read(16'h0000);
        drain();
        chk("empty_read_udf", 32'(oUNDERFLOW), 32'd1);
        chk("empty_read_level", 32'(oLEVEL), 32'd0);

        // 128-word stream, both sides reloaded together
        load(1'b1, 1'b1, 10'd0, 10'd127, 10'd0, 10'd127);
        chk("dual_load_udf_clr", 32'(oUNDERFLOW), 32'd0);
        for (int i = 0; i < 128; i++) do_write(16'(i));
        chk("stream_level_128", 32'(oLEVEL), 32'd128);
        for (int i = 0; i < 128; i++) do_read(16'(i));
        drain();
        chk("stream_level_0", 32'(oLEVEL), 32'd0);
        chk("stream_udf", 32'(oUNDERFLOW), 32'd0);

        // Short wrap window 4..6: D overwrites A
        load(1'b1, 1'b1, 10'd4, 10'd6, 10'd4, 10'd6);
        do_write(16'hAAAA); do_write(16'hBBBB); do_write(16'hCCCC); do_write(16'hDDDD);
        do_read(16'hDDDD); do_read(16'hBBBB); do_read(16'hCCCC);
        drain();
        chk("wrap46_level", 32'(oLEVEL), 32'd1);

        // Window 1022..1 passes through the top of the array
        load(1'b1, 1'b1, 10'd1022, 10'd1, 10'd1022, 10'd1);
        for (int i = 0; i < 5; i++) do_write(16'hE000 + 16'(i));
        do_read(16'hE004); do_read(16'hE001); do_read(16'hE002); do_read(16'hE003); do_read(16'hE004);
        drain();
        chk("wrap_top_level", 32'(oLEVEL), 32'd0);

        // Fill to DEPTH, then one write too many
        load(1'b1, 1'b1, 10'd0, 10'd1023, 10'd0, 10'd1023);
        for (int i = 0; i < 1024; i++) do_write(16'(i) ^ 16'h5A5A);
        chk("full_level", 32'(oLEVEL), 32'd1024);
        chk("full_no_ovf", 32'(oOVERFLOW), 32'd0);
        do_write(16'hFFFF);
        chk("ovf_set", 32'(oOVERFLOW), 32'd1);
        chk("ovf_level", 32'(oLEVEL), 32'd1024);
        for (int i = 0; i < 1024; i++) do_read(16'(i) ^ 16'h5A5A);
        drain();
        chk("drained_level", 32'(oLEVEL), 32'd0);
        chk("drained_udf", 32'(oUNDERFLOW), 32'd0);
        do_read(16'h5A5A);
        drain();
        chk("udf_set", 32'(oUNDERFLOW), 32'd1);
        chk("ovf_sticky", 32'(oOVERFLOW), 32'd1);
        load(1'b1, 1'b0, 10'd0, 10'd1023, 10'd0, 10'd1023);
        chk("wrload_ovf_clr", 32'(oOVERFLOW), 32'd0);
        chk("wrload_udf_clr", 32'(oUNDERFLOW), 32'd0);

        // Simultaneous write and read hold the level
        load(1'b1, 1'b1, 10'd0, 10'd1023, 10'd0, 10'd1023);
        for (int i = 0; i < 5; i++) do_write(16'h0100 + 16'(i));
        chk("level_5", 32'(oLEVEL), 32'd5);
        do_rw(16'h0200, 16'h0100);
        chk("rw_level_hold", 32'(oLEVEL), 32'd5);
        drain();

        // Same address read and write in one cycle returns the old word
        load(1'b1, 1'b1, 10'd20, 10'd1023, 10'd20, 10'd1023);
        do_rw(16'hBEEF, 16'h5A4E);
        chk("rbw_level", 32'(oLEVEL), 32'd0);
        load(1'b0, 1'b1, 10'd20, 10'd1023, 10'd20, 10'd1023);
        do_read(16'hBEEF);
        drain();

        // Asynchronous reset in the middle of traffic
        load(1'b1, 1'b1, 10'd0, 10'd1023, 10'd0, 10'd1023);
        do_write(16'h0111); do_write(16'h0222); do_write(16'h0333);
        do_read(16'h0111);
        drain();
        chk("pre_rst_level", 32'(oLEVEL), 32'd2);
        iWR = 1'b1; iWR_DATA = 16'h0444;
        #2;
        iRST = 1'b1;
        #1;
        chk("arst_ready", 32'(oREADY), 32'd0);
        chk("arst_level", 32'(oLEVEL), 32'd0);
        chk("arst_data", 32'(oRD_DATA), 32'd0);
        chk("arst_valid", 32'(oRD_VALID), 32'd0);
        chk("arst_ovf", 32'(oOVERFLOW), 32'd0);
        iWR = 1'b0;
        tick(); tick();
        iRST = 1'b0;
        repeat (100) tick();
        chk("mid_init_ready", 32'(oREADY), 32'd0);
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        wait_ready("reinit_cycles");
        load(1'b0, 1'b1, 10'd0, 10'd1023, 10'd0, 10'd1023);
        for (int i = 0; i < 4; i++) do_read(16'h0000);
        drain();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
